// File: rtl/crc_appender.sv
// AXI-Stream CRC-24 appender: forwards a FRAME_LEN-byte payload and appends crc[23:16], crc[15:8], crc[7:0].
// Optional `define CRC_FRAME_CNT_EN adds a frame_cnt output counting completed output frames.
module crc_appender #(
    parameter int unsigned FRAME_LEN = 236,
    parameter logic [23:0] CRC_POLY  = 24'h864CFB
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_axis_input_tvalid,
    output logic       s_axis_input_tready,
    input  logic [7:0] s_axis_input_tdata,
    input  logic       s_axis_input_tlast,
    output logic       m_axis_output_tvalid,
    input  logic       m_axis_output_tready,
    output logic [7:0] m_axis_output_tdata,
    output logic       m_axis_output_tlast,
    output logic       event_len_error
`ifdef CRC_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    typedef enum logic [1:0] {
        S_DATA,
        S_DROP,
        S_CRC
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [23:0] r_crc;
    logic [1:0]  r_crc_idx;
    logic        r_tvalid;
    logic [7:0]  r_tdata;
    logic        r_tlast;
    logic        r_len_err;

    state_t      w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic [23:0] w_crc_nxt;
    logic [1:0]  w_crc_idx_nxt;
    logic        w_tvalid_nxt;
    logic [7:0]  w_tdata_nxt;
    logic        w_tlast_nxt;
    logic        w_len_err_nxt;
    logic        w_in_ready;
    logic        w_slot_free;

    // MSB-first CRC-24 over one byte, bit 7 processed first.
    function automatic logic [23:0] crc24_byte(input logic [23:0] crc_in, input logic [7:0] data);
        logic [23:0] v;
        v = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (v[23] ^ data[i]) v = {v[22:0], 1'b0} ^ CRC_POLY;
            else                 v = {v[22:0], 1'b0};
        end
        return v;
    endfunction

    assign w_slot_free = !r_tvalid || m_axis_output_tready;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_crc_nxt     = r_crc;
        w_crc_idx_nxt = r_crc_idx;
        w_tvalid_nxt  = r_tvalid && !m_axis_output_tready;
        w_tdata_nxt   = r_tdata;
        w_tlast_nxt   = r_tlast;
        w_len_err_nxt = 1'b0;
        w_in_ready    = 1'b0;

        case (r_state)
            S_DATA: begin
                w_in_ready = w_slot_free;
                if (s_axis_input_tvalid && w_slot_free) begin
                    w_tvalid_nxt = 1'b1;
                    w_tdata_nxt  = s_axis_input_tdata;
                    w_tlast_nxt  = 1'b0;
                    w_crc_nxt    = crc24_byte(r_crc, s_axis_input_tdata);
                    if (r_cnt != LAST_IDX) w_cnt_nxt = r_cnt + 16'd1;
                    if (s_axis_input_tlast) begin
                        w_state_nxt   = S_CRC;
                        w_len_err_nxt = (r_cnt != LAST_IDX);
                    end else if (r_cnt == LAST_IDX) begin
                        // Payload full but no tlast yet: discard the overrun up to tlast.
                        w_state_nxt   = S_DROP;
                        w_len_err_nxt = 1'b1;
                    end
                end
            end
            S_DROP: begin
                w_in_ready = 1'b1;
                if (s_axis_input_tvalid && s_axis_input_tlast) w_state_nxt = S_CRC;
            end
            S_CRC: begin
                if (w_slot_free) begin
                    w_tvalid_nxt = 1'b1;
                    w_tlast_nxt  = (r_crc_idx == 2'd2);
                    case (r_crc_idx)
                        2'd0:    w_tdata_nxt = r_crc[23:16];
                        2'd1:    w_tdata_nxt = r_crc[15:8];
                        default: w_tdata_nxt = r_crc[7:0];
                    endcase
                    if (r_crc_idx == 2'd2) begin
                        w_crc_idx_nxt = 2'd0;
                        w_crc_nxt     = 24'h000000;
                        w_cnt_nxt     = 16'd0;
                        w_state_nxt   = S_DATA;
                    end else begin
                        w_crc_idx_nxt = r_crc_idx + 2'd1;
                    end
                end
            end
            default: w_state_nxt = S_DATA;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_DATA;
            r_cnt     <= 16'd0;
            r_crc     <= 24'h000000;
            r_crc_idx <= 2'd0;
            r_tvalid  <= 1'b0;
            r_tdata   <= 8'h00;
            r_tlast   <= 1'b0;
            r_len_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_crc     <= w_crc_nxt;
            r_crc_idx <= w_crc_idx_nxt;
            r_tvalid  <= w_tvalid_nxt;
            r_tdata   <= w_tdata_nxt;
            r_tlast   <= w_tlast_nxt;
            r_len_err <= w_len_err_nxt;
        end
    end

    // Gated by reset so the input never appears ready while held in reset.
    assign s_axis_input_tready  = w_in_ready && reset;
    assign m_axis_output_tvalid = r_tvalid;
    assign m_axis_output_tdata  = r_tdata;
    assign m_axis_output_tlast  = r_tlast;
    assign event_len_error      = r_len_err;

`ifdef CRC_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_frame_cnt <= 16'd0;
        else if (r_tvalid && m_axis_output_tready && r_tlast) r_frame_cnt <= r_frame_cnt + 16'd1;
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_crc_appender.sv
// Self-checking bench for crc_appender: table of FRAME_LEN=9 frames, reset-abort sequence,
// and two back-to-back 236-byte frames on a second instance.
module tb_crc_appender;

    logic       clk;
    logic       reset;
    logic       s_tvalid, s_tready, s_tlast;
    logic [7:0] s_tdata;
    logic       m_tvalid, m_tready, m_tlast;
    logic [7:0] m_tdata;
    logic       len_err;

    logic       l_s_tvalid, l_s_tready, l_s_tlast;
    logic [7:0] l_s_tdata;
    logic       l_m_tvalid, l_m_tready, l_m_tlast;
    logic [7:0] l_m_tdata;
    logic       l_len_err;

`ifdef CRC_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic [15:0] l_frame_cnt;
`endif

    crc_appender #(.FRAME_LEN(9)) u_dut (
        .clk                 (clk),
        .reset               (reset),
        .s_axis_input_tvalid (s_tvalid),
        .s_axis_input_tready (s_tready),
        .s_axis_input_tdata  (s_tdata),
        .s_axis_input_tlast  (s_tlast),
        .m_axis_output_tvalid(m_tvalid),
        .m_axis_output_tready(m_tready),
        .m_axis_output_tdata (m_tdata),
        .m_axis_output_tlast (m_tlast),
        .event_len_error     (len_err)
`ifdef CRC_FRAME_CNT_EN
        ,
        .frame_cnt           (frame_cnt)
`endif
    );

    crc_appender #(.FRAME_LEN(236)) u_dut_long (
        .clk                 (clk),
        .reset               (reset),
        .s_axis_input_tvalid (l_s_tvalid),
        .s_axis_input_tready (l_s_tready),
        .s_axis_input_tdata  (l_s_tdata),
        .s_axis_input_tlast  (l_s_tlast),
        .m_axis_output_tvalid(l_m_tvalid),
        .m_axis_output_tready(l_m_tready),
        .m_axis_output_tdata (l_m_tdata),
        .m_axis_output_tlast (l_m_tlast),
        .event_len_error     (l_len_err)
`ifdef CRC_FRAME_CNT_EN
        ,
        .frame_cnt           (l_frame_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference CRC-24 (MSB-first, init 0, poly 864CFB).
    function automatic logic [23:0] crc_of(input logic [7:0] b[$]);
        logic [23:0] c;
        c = 24'h000000;
        foreach (b[j]) begin
            for (int i = 7; i >= 0; i--) begin
                logic fb;
                fb = c[23] ^ b[j][i];
                c  = {c[22:0], 1'b0};
                if (fb) c = c ^ 24'h864CFB;
            end
        end
        return c;
    endfunction

    // Output monitors sample on the falling edge, between driver updates and the next transfer edge.
    logic [8:0] out_q[$];
    int         err_cycles;
    int         timeouts;
    bit         rand_ready;

    always @(negedge clk) begin
        if (reset) begin
            if (m_tvalid && m_tready) out_q.push_back({m_tlast, m_tdata});
            if (len_err) err_cycles++;
        end
    end

    always @(posedge clk) begin
        #1;
        m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic [8:0] l_q[$];
    int         l_gaps;
    int         l_err_cycles;

    always @(negedge clk) begin
        if (reset) begin
            if (l_m_tvalid && l_m_tready) l_q.push_back({l_m_tlast, l_m_tdata});
            else if (l_q.size() > 0 && l_q.size() < 478) l_gaps++;
            if (l_len_err) l_err_cycles++;
        end
    end

    // Sends n bytes "1","2",... ; tlast on index tlast_idx (-1 = none).
    task automatic send_bytes(input int n, input int tlast_idx, input bit gaps);
        for (int k = 0; k < n; k++) begin
            int w;
            if (gaps && $urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
                s_tvalid = 1'b0;
            end
            @(posedge clk); #1;
            s_tvalid = 1'b1;
            s_tdata  = 8'h31 + 8'(k);
            s_tlast  = (k == tlast_idx);
            w = 0;
            @(negedge clk);
            while (!s_tready && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (w >= 200) timeouts++;
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    typedef struct {
        string       name;
        int          n_bytes;
        bit          gaps;
        bit          rand_ready;
        int          exp_err;
        bit          crc_known;
        logic [23:0] exp_crc;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v);
        logic [7:0]  pl[$];
        logic [8:0]  exp_q[$];
        logic [23:0] crc;
        int          kept;
        out_q.delete();
        err_cycles = 0;
        timeouts   = 0;
        rand_ready = v.rand_ready;
        kept = (v.n_bytes < 9) ? v.n_bytes : 9;
        for (int k = 0; k < kept; k++) begin
            pl.push_back(8'h31 + 8'(k));
            exp_q.push_back({1'b0, 8'h31 + 8'(k)});
        end
        crc = v.crc_known ? v.exp_crc : crc_of(pl);
        exp_q.push_back({1'b0, crc[23:16]});
        exp_q.push_back({1'b0, crc[15:8]});
        exp_q.push_back({1'b1, crc[7:0]});
        send_bytes(v.n_bytes, v.n_bytes - 1, v.gaps);
        for (int c = 0; c < 2000 && out_q.size() < exp_q.size(); c++) @(posedge clk);
        repeat (6) @(posedge clk);
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        check({v.name, "_timeout"}, 32'(timeouts), 0);
        check({v.name, "_len"}, 32'(out_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            logic [8:0] got;
            got = (i < out_q.size()) ? out_q[i] : 9'h1FF;
            check($sformatf("%s_byte%0d", v.name, i), 32'(got), 32'(exp_q[i]));
        end
        check({v.name, "_len_err"}, 32'(err_cycles), 32'(v.exp_err));
    endtask

    initial begin
        logic [7:0] pl[$];
        int         w;
        int         bad;

        vecs[0] = '{"nominal",    9,  1'b0, 1'b0, 0, 1'b1, 24'hCDE703};
        vecs[1] = '{"stall_gaps", 9,  1'b1, 1'b1, 0, 1'b1, 24'hCDE703};
        vecs[2] = '{"short_1234", 4,  1'b0, 1'b1, 1, 1'b0, 24'h000000};
        vecs[3] = '{"long_12",    12, 1'b1, 1'b0, 1, 1'b1, 24'hCDE703};
        vecs[4] = '{"recover",    9,  1'b0, 1'b1, 0, 1'b1, 24'hCDE703};

        reset      = 1'b0;
        rand_ready = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = 8'h00;
        s_tlast    = 1'b0;
        m_tready   = 1'b1;
        l_s_tvalid = 1'b0;
        l_s_tdata  = 8'h00;
        l_s_tlast  = 1'b0;
        l_m_tready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tvalid", 32'(m_tvalid), 0);
        check("rst_tdata",  32'(m_tdata), 0);
        check("rst_tlast",  32'(m_tlast), 0);
        check("rst_len_err", 32'(len_err), 0);
        check("rst_s_tready", 32'(s_tready), 0);
`ifdef CRC_FRAME_CNT_EN
        check("rst_frame_cnt", 32'(frame_cnt), 0);
`endif
        reset = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);
`ifdef CRC_FRAME_CNT_EN
        check("frame_cnt_5", 32'(frame_cnt), 5);
`endif

        // Reset in the middle of a frame: four bytes in, fifth presented, then reset.
        timeouts = 0;
        send_bytes(4, -1, 1'b0);
        s_tvalid = 1'b1;
        s_tdata  = 8'h35;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_tvalid", 32'(m_tvalid), 0);
        check("midrst_tdata",  32'(m_tdata), 0);
        check("midrst_tlast",  32'(m_tlast), 0);
        check("midrst_s_tready", 32'(s_tready), 0);
        s_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_vec(vecs[0]);
`ifdef CRC_FRAME_CNT_EN
        check("frame_cnt_after_rst", 32'(frame_cnt), 1);
`endif

        // Two back-to-back 236-byte frames of bytes 0..235 on the long instance.
        l_q.delete();
        l_gaps       = 0;
        l_err_cycles = 0;
        timeouts     = 0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 236; k++) begin
                @(posedge clk); #1;
                l_s_tvalid = 1'b1;
                l_s_tdata  = 8'(k);
                l_s_tlast  = (k == 235);
                w = 0;
                @(negedge clk);
                while (!l_s_tready && w < 100) begin
                    @(negedge clk);
                    w++;
                end
                if (w >= 100) timeouts++;
            end
        end
        @(posedge clk); #1;
        l_s_tvalid = 1'b0;
        l_s_tlast  = 1'b0;
        for (int c = 0; c < 1000 && l_q.size() < 478; c++) @(posedge clk);
        repeat (4) @(posedge clk);
        check("long_timeout", 32'(timeouts), 0);
        check("long_len", 32'(l_q.size()), 478);
        check("long_gaps", 32'(l_gaps), 0);
        check("long_len_err", 32'(l_err_cycles), 0);
        for (int f = 0; f < 2; f++) begin
            logic [23:0] rx_crc;
            pl.delete();
            bad = 0;
            for (int k = 0; k < 239; k++) begin
                logic [8:0] got;
                got = (f * 239 + k < l_q.size()) ? l_q[f * 239 + k] : 9'h1FF;
                if (k < 236) begin
                    pl.push_back(got[7:0]);
                    if (got !== {1'b0, 8'(k)}) bad++;
                end else begin
                    rx_crc = {rx_crc[15:0], got[7:0]};
                    if (got[8] !== (k == 238)) bad++;
                end
            end
            check($sformatf("long_f%0d_stream", f), 32'(bad), 0);
            check($sformatf("long_f%0d_rx_crc", f), 32'(rx_crc), 32'(crc_of(pl)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
